zx8302_irqc: RTL and testbench

- Parametrised successor to the fixed ZX8302 interrupt logic (gap/vsync/xint latches with 3-bit mask and write-1 ack).
- Handles NUM_SRC sources, each with a synchroniser, a glitch filter, a mask bit and an edge/level mode bit.
- Merges the pending state into the active-low IPL pair shared with the IPC.
- Sits behind the ZX8302 bus decode in the 0x18xxx I/O area and replaces the per-source asynchronous latches with one fully synchronous block.

---
 rtl/zx8302_irqc_if.sv | 22 ++
 rtl/zx8302_irqc.sv | 133 +++++++++++++
 tb/tb_zx8302_irqc.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zx8302_irqc_if.sv
// CPU-side register bus of the ZX8302 interrupt controller (0x18xxx I/O window).
// Combinational read path, single-cycle writes qualified by cen.
// No flow control: every selected access completes in the cycle it is presented.
interface zx8302_irqc_if;
   logic        cen;
   logic        cpu_sel;
   logic        cpu_wr;
   logic [1:0]  cpu_addr;
   logic [1:0]  cpu_ds;
   logic [15:0] cpu_din;
   logic [15:0] cpu_dout;

   modport master (
      output cen, cpu_sel, cpu_wr, cpu_addr, cpu_ds, cpu_din,
      input  cpu_dout
   );

   modport slave (
      input  cen, cpu_sel, cpu_wr, cpu_addr, cpu_ds, cpu_din,
      output cpu_dout
   );
endinterface

// File: rtl/zx8302_irqc.sv
// Synchronised, glitch-filtered, maskable edge/level interrupt controller merged into the IPL pair.
// Latency: src edge to pending is SYNC_STAGES+FILTER_LEN+1 clk; ipl and irq_any follow one clk later.
// No backpressure: register writes complete on the clk edge where cen & cpu_sel & cpu_wr.
module zx8302_irqc #(
   parameter int NUM_SRC     = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic               clk,
   input  logic               reset,
   zx8302_irqc_if.slave       bus,
   input  logic [NUM_SRC-1:0] src,
   input  logic [1:0]         ipc_ipl,
   output logic [1:0]         ipl,
   output logic               irq_any
);
   // Counter value on which the filter accepts the new level (counter is cleared at the same time).
   localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

   logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
   logic [NUM_SRC-1:0] synced;
   logic [NUM_SRC-1:0] filt;
   logic [3:0]         cnt [NUM_SRC];
   logic [NUM_SRC-1:0] gated;
   logic [NUM_SRC-1:0] gated_d;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] pend_nxt;
   logic [NUM_SRC-1:0] mask_q;
   logic [NUM_SRC-1:0] mode_q;
   logic               wr_en;
   logic [15:0]        lane_en;
   logic [NUM_SRC-1:0] lane_n;
   logic [NUM_SRC-1:0] din_n;
   logic [NUM_SRC-1:0] ack;
   logic [15:0]        rd_dat;
   logic               unused_bits;

   // Synchroniser chain for the asynchronous sources; free-running, not gated by cen.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= src;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   // Glitch filter: a new synced level must persist FILTER_LEN clks before filt follows it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt <= '0;
         for (int i = 0; i < NUM_SRC; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (synced[i] == filt[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == FILT_LAST) begin
               filt[i] <= synced[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + 4'd1;
            end
         end
      end
   end

   // Write decode, ack mask and next pending state (edge: set beats ack; level: copy gated).
   always_comb begin
      wr_en    = bus.cen & bus.cpu_sel & bus.cpu_wr;
      lane_en  = {{8{~bus.cpu_ds[1]}}, {8{~bus.cpu_ds[0]}}};
      lane_n   = lane_en[NUM_SRC-1:0];
      din_n    = bus.cpu_din[NUM_SRC-1:0];
      ack      = (wr_en && bus.cpu_addr == 2'd0) ? (din_n & lane_n) : '0;
      gated    = filt & mask_q;
      rise     = gated & ~gated_d;
      pend_nxt = (mode_q & gated) | (~mode_q & (rise | (pending & ~ack)));
   end

   // Bits of the 16-bit bus beyond NUM_SRC have no storage behind them.
   assign unused_bits = ^{lane_en, bus.cpu_din};

   // MASK and MODE registers, byte-lane qualified; STATUS is read-only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q <= '0;
         mode_q <= '0;
      end else if (wr_en) begin
         if (bus.cpu_addr == 2'd1) mask_q <= (mask_q & ~lane_n) | (din_n & lane_n);
         if (bus.cpu_addr == 2'd2) mode_q <= (mode_q & ~lane_n) | (din_n & lane_n);
      end
   end

   // Pending latch plus the delayed gated copy used for rising-edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
         gated_d <= '0;
      end else begin
         pending <= pend_nxt;
         gated_d <= gated;
      end
   end

   // Registered interrupt outputs: any pending pulls IPL1 low (level 2), IPC lines pass through.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_any <= 1'b0;
         ipl     <= 2'b11;
      end else begin
         irq_any <= |pending;
         ipl     <= {ipc_ipl[1] & ~(|pending), ipc_ipl[0]};
      end
   end

   // Combinational read mux; unselected bus reads as zero.
   always_comb begin
      rd_dat = '0;
      if (bus.cpu_sel) begin
         case (bus.cpu_addr)
            2'd0:    rd_dat[NUM_SRC-1:0] = pending;
            2'd1:    rd_dat[NUM_SRC-1:0] = mask_q;
            2'd2:    rd_dat[NUM_SRC-1:0] = mode_q;
            default: rd_dat[NUM_SRC-1:0] = filt;
         endcase
      end
   end

   assign bus.cpu_dout = rd_dat;

endmodule

// File: tb/tb_zx8302_irqc.sv
// Self-checking bench for zx8302_irqc: register table, directed corner sequences, random vs model.
// Inputs change 1 ns after the rising edge; outputs are sampled at that point too.
// Model derives filtered levels from a window over the sampled source history.
module tb_zx8302_irqc;
   localparam int N  = 8;
   localparam int SS = 2;
   localparam int FL = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] src;
   logic [1:0]   ipc_ipl;
   logic [1:0]   ipl;
   logic         irq_any;

   zx8302_irqc_if bus();

   zx8302_irqc #(.NUM_SRC(N), .SYNC_STAGES(SS), .FILTER_LEN(FL)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .src     (src),
      .ipc_ipl (ipc_ipl),
      .ipl     (ipl),
      .irq_any (irq_any)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [N-1:0] m_filt, m_mask, m_mode, m_pend, m_gd;
   logic         m_irq;
   logic [1:0]   m_ipl;
   logic [N-1:0] shist[$];

   typedef struct {
      logic        cen;
      logic        sel;
      logic        wr;
      logic [1:0]  addr;
      logic [1:0]  ds;
      logic [15:0] din;
      logic [15:0] exp;
   } vec_t;
   vec_t tbl[15];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_filt = '0; m_mask = '0; m_mode = '0; m_pend = '0; m_gd = '0;
      m_irq  = 1'b0;
      m_ipl  = 2'b11;
      shist.delete();
   endtask

   // One clk edge of the reference model, using the inputs present at that edge.
   task automatic model_step();
      logic         wen;
      logic [15:0]  lane16;
      logic [N-1:0] lane, din, g, ackv, newf;
      logic         v, stable;
      int           k, j;
      wen    = bus.cen & bus.cpu_sel & bus.cpu_wr;
      lane16 = {{8{~bus.cpu_ds[1]}}, {8{~bus.cpu_ds[0]}}};
      lane   = lane16[N-1:0];
      din    = bus.cpu_din[N-1:0];
      g      = m_filt & m_mask;
      ackv   = (wen && bus.cpu_addr == 2'd0) ? (din & lane) : '0;
      m_irq  = |m_pend;
      m_ipl  = {ipc_ipl[1] & ~(|m_pend), ipc_ipl[0]};
      for (int i = 0; i < N; i++) begin
         if (m_mode[i])              m_pend[i] = g[i];
         else if (g[i] && !m_gd[i])  m_pend[i] = 1'b1;
         else if (ackv[i])           m_pend[i] = 1'b0;
      end
      m_gd = g;
      // filt flips once the last FL synchronised samples all disagree with it.
      shist.push_back(src);
      k = shist.size() - 1;
      for (int i = 0; i < N; i++) begin
         stable = 1'b1;
         for (int d = 0; d < FL; d++) begin
            j = k - SS - d;
            v = (j >= 0) ? shist[j][i] : 1'b0;
            if (v == m_filt[i]) stable = 1'b0;
         end
         newf[i] = stable ? ~m_filt[i] : m_filt[i];
      end
      m_filt = newf;
      if (wen && bus.cpu_addr == 2'd1) m_mask = (m_mask & ~lane) | (din & lane);
      if (wen && bus.cpu_addr == 2'd2) m_mode = (m_mode & ~lane) | (din & lane);
   endtask

   function automatic logic [15:0] model_read();
      logic [15:0] r;
      r = '0;
      if (bus.cpu_sel) begin
         case (bus.cpu_addr)
            2'd0:    r[N-1:0] = m_pend;
            2'd1:    r[N-1:0] = m_mask;
            2'd2:    r[N-1:0] = m_mode;
            default: r[N-1:0] = m_filt;
         endcase
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [1:0] ds, input logic [15:0] d);
      bus.cpu_wr   = 1'b1;
      bus.cpu_addr = a;
      bus.cpu_ds   = ds;
      bus.cpu_din  = d;
      tick();
      bus.cpu_wr   = 1'b0;
   endtask

   task automatic rdchk(input string name, input logic [1:0] a, input logic [15:0] exp);
      bus.cpu_addr = a;
      #1;
      chk(name, bus.cpu_dout, exp);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cen = 1'b1; bus.cpu_sel = 1'b1; bus.cpu_wr = 1'b0;
      bus.cpu_addr = 2'd0; bus.cpu_ds = 2'b00; bus.cpu_din = '0;
      src = '0; ipc_ipl = 2'b11;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;

      // Reset state.
      rdchk("rst_pending", 2'd0, 16'h0000);
      rdchk("rst_mask",    2'd1, 16'h0000);
      rdchk("rst_mode",    2'd2, 16'h0000);
      rdchk("rst_status",  2'd3, 16'h0000);
      chk("rst_ipl", 16'(ipl), 16'h0003);
      chk("rst_irq", 16'(irq_any), 16'h0000);

      // Register-map table: {cen, sel, wr, addr, ds, din, expected readback after the edge}.
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 2'd1, 2'b00, 16'hFFFF, 16'h00FF};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 2'd1, 2'b10, 16'h0000, 16'h0000};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 2'd1, 2'b01, 16'hAAAA, 16'h0000};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 2'd1, 2'b00, 16'h00AA, 16'h0000};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 2'd2, 2'b00, 16'h125A, 16'h005A};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 2'd1, 2'b00, 16'h00FF, 16'h0000};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 2'd1, 2'b00, 16'h00C3, 16'h0000};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 2'd1, 2'b00, 16'h0000, 16'h0000};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'd3, 2'b00, 16'h00FF, 16'h0000};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 2'd2, 2'b00, 16'h0000, 16'h005A};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 2'd0, 2'b00, 16'h0000, 16'h0000};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 2'd1, 2'b00, 16'h0081, 16'h0081};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 2'd1, 2'b01, 16'h00FF, 16'h0081};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 2'd1, 2'b00, 16'h0000, 16'h0000};
      tbl[14] = '{1'b1, 1'b1, 1'b1, 2'd2, 2'b00, 16'h0000, 16'h0000};
      for (int t = 0; t < 15; t++) begin
         bus.cen = tbl[t].cen; bus.cpu_sel = tbl[t].sel; bus.cpu_wr = tbl[t].wr;
         bus.cpu_addr = tbl[t].addr; bus.cpu_ds = tbl[t].ds; bus.cpu_din = tbl[t].din;
         tick();
         chk($sformatf("tbl%0d", t), bus.cpu_dout, tbl[t].exp);
      end
      bus.cen = 1'b1; bus.cpu_sel = 1'b1; bus.cpu_wr = 1'b0;

      // Edge source: exact 6-clk latency, outputs one clk later.
      wr(2'd1, 2'b00, 16'h0001);
      bus.cpu_addr = 2'd0;
      src = 8'h01;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k <= 6) chk($sformatf("lat_pend_k%0d", k), bus.cpu_dout, (k == 6) ? 16'h0001 : 16'h0000);
         if (k == 6) begin
            chk("lat_ipl_k6", 16'(ipl), 16'h0003);
            chk("lat_irq_k6", 16'(irq_any), 16'h0000);
         end
         if (k == 7) begin
            chk("lat_ipl_k7", 16'(ipl), 16'h0001);
            chk("lat_irq_k7", 16'(irq_any), 16'h0001);
         end
      end
      src = '0;
      repeat (8) tick();
      rdchk("edge_latched", 2'd0, 16'h0001);
      wr(2'd0, 2'b00, 16'hFFFF);
      rdchk("edge_acked", 2'd0, 16'h0000);

      // Glitch rejection, then a minimal 3-clk pulse.
      wr(2'd1, 2'b00, 16'h00FF);
      bus.cpu_addr = 2'd3;
      src = 8'h02;
      tick(); tick();
      src = '0;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk($sformatf("glitch_status%0d", k), bus.cpu_dout, 16'h0000);
      end
      rdchk("glitch_pend", 2'd0, 16'h0000);
      bus.cpu_addr = 2'd3;
      src = 8'h02;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k == 3) src = '0;
         chk($sformatf("pulse3_status_k%0d", k), bus.cpu_dout, (k == 5) ? 16'h0002 : 16'h0000);
      end
      bus.cpu_addr = 2'd0;
      tick();
      chk("pulse3_pend", bus.cpu_dout, 16'h0002);

      // Byte-lane qualified acks.
      src = 8'h01;
      repeat (4) tick();
      src = '0;
      repeat (8) tick();
      rdchk("lane_pre", 2'd0, 16'h0003);
      wr(2'd0, 2'b10, 16'h0001);
      rdchk("lane_low_ack", 2'd0, 16'h0002);
      wr(2'd0, 2'b01, 16'h0001);
      rdchk("lane_high_only", 2'd0, 16'h0002);
      wr(2'd0, 2'b00, 16'hFFFF);
      rdchk("lane_clear", 2'd0, 16'h0000);

      // Mask toggle with source held high; ack colliding with a new set.
      wr(2'd1, 2'b00, 16'h00FB);
      src = 8'h04;
      repeat (8) tick();
      rdchk("mtog_masked", 2'd0, 16'h0000);
      wr(2'd1, 2'b00, 16'h00FF);
      rdchk("mtog_same_clk", 2'd0, 16'h0000);
      tick();
      chk("mtog_next_clk", bus.cpu_dout, 16'h0004);
      wr(2'd1, 2'b00, 16'h00FB);
      rdchk("mask_clr_keeps", 2'd0, 16'h0004);
      wr(2'd0, 2'b00, 16'hFFFF);
      rdchk("mtog_acked", 2'd0, 16'h0000);
      wr(2'd1, 2'b00, 16'h00FF);
      wr(2'd0, 2'b00, 16'h0004);
      rdchk("set_beats_ack", 2'd0, 16'h0004);
      tick();
      chk("set_beats_ack_hold", bus.cpu_dout, 16'h0004);

      // Level mode follows the filtered level; ack has no lasting effect.
      src = '0;
      repeat (8) tick();
      wr(2'd0, 2'b00, 16'hFFFF);
      rdchk("lvl_pre", 2'd0, 16'h0000);
      ipc_ipl = 2'b10;
      wr(2'd1, 2'b00, 16'h0008);
      wr(2'd2, 2'b00, 16'h0008);
      bus.cpu_addr = 2'd0;
      src = 8'h08;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("lvl_rise_k%0d", k), bus.cpu_dout, (k == 6) ? 16'h0008 : 16'h0000);
      end
      wr(2'd0, 2'b00, 16'h0008);
      rdchk("lvl_ack_ignored", 2'd0, 16'h0008);
      chk("lvl_ipl_forced", 16'(ipl), 16'h0000);
      src = '0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k <= 6) chk($sformatf("lvl_fall_k%0d", k), bus.cpu_dout, (k == 6) ? 16'h0000 : 16'h0008);
         if (k == 7) chk("lvl_ipl_passthru", 16'(ipl), 16'h0002);
      end

      // Reset mid-filter discards everything; fresh latency afterwards.
      ipc_ipl = 2'b11;
      wr(2'd2, 2'b00, 16'h0000);
      wr(2'd1, 2'b00, 16'h00FF);
      src = 8'hFF;
      repeat (7) tick();
      rdchk("pre_rst_pend", 2'd0, 16'h00FF);
      wr(2'd2, 2'b00, 16'h00F0);
      src = '0;
      repeat (3) tick();
      rdchk("pre_rst_hold", 2'd0, 16'h00FF);
      src = 8'hFF;
      #2;
      reset = 1'b1;
      model_reset();
      rdchk("mid_rst_pend",   2'd0, 16'h0000);
      rdchk("mid_rst_mask",   2'd1, 16'h0000);
      rdchk("mid_rst_mode",   2'd2, 16'h0000);
      rdchk("mid_rst_status", 2'd3, 16'h0000);
      chk("mid_rst_ipl", 16'(ipl), 16'h0003);
      chk("mid_rst_irq", 16'(irq_any), 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      wr(2'd1, 2'b00, 16'h00FF);
      bus.cpu_addr = 2'd0;
      for (int k = 2; k <= 6; k++) begin
         tick();
         chk($sformatf("post_rst_k%0d", k), bus.cpu_dout, (k == 6) ? 16'h00FF : 16'h0000);
      end

      // Randomised traffic against the reference model.
      @(negedge clk) reset = 1'b1;
      model_reset();
      src = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(4) == 0) src[i] = ~src[i];
         if ($urandom_range(7) == 0) ipc_ipl = 2'($urandom_range(3));
         bus.cen      = ($urandom_range(3) != 0);
         bus.cpu_sel  = ($urandom_range(7) != 0);
         bus.cpu_wr   = ($urandom_range(5) == 0);
         bus.cpu_addr = 2'($urandom_range(3));
         bus.cpu_ds   = 2'($urandom_range(3));
         bus.cpu_din  = 16'($urandom);
         tick();
         chk("rnd_dout", bus.cpu_dout, model_read());
         chk("rnd_ipl", 16'(ipl), 16'(m_ipl));
         chk("rnd_irq", 16'(irq_any), 16'(m_irq));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
